mux8way_rr: RTL and testbench
=============================

Name: mux8way_rr

Overview:
- Sequential 8-to-1 multiplexer: the collecting end of the 8-way fan-out path.
- Merges eight valid/ready word streams into one output stream.
- Uses round-robin arbitration, optional burst locking, and a registered output stage.
- The output carries the 3-bit source channel number, encoded the same way the 8-way demux consumes its select. Downstream logic can therefore route a response back to the originating channel.

Parameters:
- WIDTH, 16: data word width in bits (Hack word).
- LOCK_BURSTS, 1: 1 = grant held on a channel until a beat with in_last=1 is accepted; 0 = re-arbitrate every beat.

Ports:
- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  8*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- in_valid  input  8  channel i offers a word
- in_last  input  8  channel i word ends a burst (ignored when LOCK_BURSTS=0)
- in_ready  output  8  channel i word accepted this cycle when in_valid[i]&in_ready[i]
- out_data  output  WIDTH  registered selected word
- out_sel  output  3  channel number of out_data, bit 0 = LSB
- out_last  output  1  registered in_last of the selected word
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word when out_valid&out_ready

Behaviour:
- Reset (reset_n low, async, any time incl. mid-burst):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - last-grant pointer=7, so channel 0 has top priority; lock cleared.
  - in_ready combinationally 0 while reset_n low.
  - A word held in the output register at reset is discarded.
- Load enable: load = !out_valid | out_ready. The register may refill in the same cycle it drains, giving full throughput of one word per cycle.
- Arbitration (combinational, each cycle):
  - If locked, the candidate is the locked channel only.
  - Otherwise the candidate is the first i with in_valid[i]=1, scanning (ptr+1), (ptr+2), ... modulo 8, wrapping 7->0.
  - No valid channel means no candidate.
- in_ready[i] = load & (i == candidate) & a candidate exists.
  - At most one in_ready bit is high; it is one-hot or zero.
  - in_ready may depend on in_valid. Sources must not make in_valid depend on in_ready.
- Accept (in_valid[c]&in_ready[c] at an edge), on the next cycle:
  - out_data=in_data[c], out_sel=c, out_last=in_last[c], out_valid=1.
  - ptr<=c. Latency is exactly 1 cycle from accept to out_valid.
- Drain with no accept (out_valid&out_ready and no candidate): out_valid<=0. out_data/out_sel/out_last hold their last values.
- Stall (out_valid&!out_ready): all output registers hold and in_ready=0. A valid input with no accept is not consumed.
- Lock (LOCK_BURSTS=1):
  - On an accept with in_last[c]=0, lock<=1 and lock channel<=c.
  - On an accept with in_last[c]=1, lock<=0.
  - While locked, other channels are never granted, even if the locked channel drops in_valid (bubbles allowed). There is no timeout.
- LOCK_BURSTS=0: lock is never set. ptr advances every accept, so each valid channel gets one beat per rotation.
- Fairness: with all 8 channels continuously valid and single-beat bursts, the grant order is 0,1,2,...,7,0,... with one word per cycle when out_ready=1.
- Simultaneous drain + accept in one cycle: the new word replaces the old one and out_valid stays 1.

Test Plan:
- Reset then idle: reset_n low mid-stream, then released with in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=8'h00 on every cycle.
- Round-robin: in_valid=8'hFF, in_last=8'hFF, in_data[i]=16'h0A00+i, out_ready=1 -> out_sel sequence 0..7,0,1 with out_data 16'h0A00..16'h0A07 on consecutive cycles, 1-cycle latency after the first accept.
- Wrap and skip: only channels 2 and 6 valid, ptr=6 -> grant 2 then 6 then 2; out_sel alternates 2,6,2; in_ready never asserted for other channels.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=16'h1234 -> all outputs hold and in_ready=0. Raise out_ready -> 16'h1234 consumed and next word loaded the same edge.
- Burst lock: channel 3 sends 4 beats with in_last=0,0,0,1 and a 1-cycle in_valid bubble after beat 2, while channel 4 is continuously valid -> out_sel=3 for all 4 beats, then out_sel=4. With LOCK_BURSTS=0, beats interleave 3,4,3,4.
- Reset mid-burst: assert reset_n low while locked on channel 5 with out_valid=1 -> outputs clear immediately. After release, channel 0 wins over channel 5 when both are valid.

Source files
------------

// File: rtl/mux8way_rr_if.sv
// Stream bundle for the 8-to-1 round-robin merge: eight valid/ready input
// lanes plus one registered output lane carrying the source channel number.
interface mux8way_rr_if #(
    parameter int WIDTH = 16
);
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_last;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    // master drives the input lanes and consumes the output lane
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_sel, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_sel, out_last, out_valid
    );
endinterface

// File: rtl/mux8way_rr.sv
// Sequential 8-to-1 stream merge: round-robin grant, optional burst lock,
// registered output stage that refills in the cycle it drains.
//
// state     | meaning
// ST_OPEN   | no burst in flight, round-robin scan from ptr+1
// ST_LOCKED | burst in flight, only lock_ch may be granted
module mux8way_rr #(
    parameter int WIDTH       = 16,
    parameter bit LOCK_BURSTS = 1'b1
) (
    input logic         clk,
    input logic         reset_n,
    mux8way_rr_if.slave bus
);
    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [2:0]         lock_ch_q, lock_ch_d;
    logic [2:0]         ptr_q;
    logic [2:0]         cand;
    logic               has_cand;
    logic               load;
    logic               accept;
    logic [WIDTH-1:0]   data_q;
    logic [2:0]         sel_q;
    logic               last_q;
    logic               valid_q;

    assign load   = !valid_q || bus.out_ready;
    assign accept = has_cand && load && reset_n;

    always_comb begin
        cand     = '0;
        has_cand = 1'b0;
        if (state_q == ST_LOCKED) begin
            cand     = lock_ch_q;
            has_cand = bus.in_valid[lock_ch_q];
        end else begin
            // k=8 wraps back to ptr itself, so the last granted channel is tried last
            for (int k = 1; k <= 8; k++) begin
                if (!has_cand && bus.in_valid[ptr_q + 3'(k)]) begin
                    cand     = ptr_q + 3'(k);
                    has_cand = 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = accept ? (8'(1) << cand) : 8'h00;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (accept && LOCK_BURSTS) begin
            if (bus.in_last[cand]) begin
                state_d = ST_OPEN;
            end else begin
                state_d   = ST_LOCKED;
                lock_ch_d = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_OPEN;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= 3'd7;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            ptr_q   <= cand;
            data_q  <= bus.in_data[cand*WIDTH +: WIDTH];
            sel_q   <= cand;
            last_q  <= bus.in_last[cand];
            valid_q <= 1'b1;
        end else if (load) begin
            // drained with nothing to replace it; payload fields keep their last values
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux8way_rr.sv
// Directed bench for mux8way_rr: one locking and one non-locking instance
// driven by the same stimulus, each checked against hand-computed values.
module tb_mux8way_rr;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [8*W-1:0] in_data = '0;
    logic [7:0]     in_valid = '0;
    logic [7:0]     in_last = '0;
    logic           out_ready = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    mux8way_rr_if #(.WIDTH(W)) ifa ();
    mux8way_rr_if #(.WIDTH(W)) ifb ();

    assign ifa.in_data   = in_data;
    assign ifa.in_valid  = in_valid;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = out_ready;
    assign ifb.in_data   = in_data;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = out_ready;

    mux8way_rr #(.WIDTH(W), .LOCK_BURSTS(1'b1)) dut_lock (
        .clk(clk), .reset_n(reset_n), .bus(ifa)
    );
    mux8way_rr #(.WIDTH(W), .LOCK_BURSTS(1'b0)) dut_free (
        .clk(clk), .reset_n(reset_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // reset, then a word stalled in the output register, then reset mid-stream
        #1;
        chk("rst_valid", 32'(ifa.out_valid), 0);
        chk("rst_ready", 32'(ifa.in_ready), 0);
        tick();
        tick();
        reset_n         = 1'b1;
        in_data[0 +: W] = 16'h5555;
        in_valid        = 8'h01;
        in_last         = 8'h01;
        out_ready       = 1'b0;
        #1;
        chk("pre_ready", 32'(ifa.in_ready), 32'h01);
        tick();
        chk("stall_valid", 32'(ifa.out_valid), 1);
        chk("stall_data", 32'(ifa.out_data), 32'h5555);
        chk("stall_ready", 32'(ifa.in_ready), 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ifa.out_valid), 0);
        chk("midrst_data", 32'(ifa.out_data), 0);
        chk("midrst_ready", 32'(ifa.in_ready), 0);
        in_valid = 8'h00;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_valid", 32'(ifa.out_valid), 0);
            chk("idle_data", 32'(ifa.out_data), 0);
            chk("idle_sel", 32'(ifa.out_sel), 0);
            chk("idle_ready", 32'(ifa.in_ready), 0);
        end

        // round-robin with everyone valid, single-beat bursts
        for (int i = 0; i < 8; i++) in_data[i*W +: W] = 16'h0A00 + 16'(i);
        in_valid  = 8'hFF;
        in_last   = 8'hFF;
        out_ready = 1'b1;
        #1;
        chk("rr_first_ready", 32'(ifa.in_ready), 32'h01);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rr_valid", 32'(ifa.out_valid), 1);
            chk("rr_sel", 32'(ifa.out_sel), 32'(k % 8));
            chk("rr_data", 32'(ifa.out_data), 32'h0A00 + 32'(k % 8));
            chk("rr_ready", 32'(ifa.in_ready), 32'(8'(1) << ((k + 1) % 8)));
            chk("rr_sel_free", 32'(ifb.out_sel), 32'(k % 8));
        end
        in_valid = 8'h00;
        tick();
        chk("drain_valid", 32'(ifa.out_valid), 0);
        chk("drain_sel_hold", 32'(ifa.out_sel), 1);
        chk("drain_data_hold", 32'(ifa.out_data), 32'h0A01);

        // wrap and skip: park ptr on 6, then only 2 and 6 valid
        in_valid = 8'h40;
        tick();
        chk("ws_sel6", 32'(ifa.out_sel), 6);
        in_valid = 8'h44;
        #1;
        chk("ws_ready_a", 32'(ifa.in_ready), 32'h04);
        tick();
        chk("ws_sel_a", 32'(ifa.out_sel), 2);
        chk("ws_ready_b", 32'(ifa.in_ready), 32'h40);
        tick();
        chk("ws_sel_b", 32'(ifa.out_sel), 6);
        chk("ws_ready_c", 32'(ifa.in_ready), 32'h04);
        tick();
        chk("ws_sel_c", 32'(ifa.out_sel), 2);
        in_valid = 8'h00;
        tick();

        // backpressure: 0x1234 held for three cycles, then drained and replaced together
        in_data[1*W +: W] = 16'h1234;
        in_valid          = 8'h02;
        tick();
        chk("bp_load_data", 32'(ifa.out_data), 32'h1234);
        chk("bp_load_sel", 32'(ifa.out_sel), 1);
        out_ready         = 1'b0;
        in_data[1*W +: W] = 16'h5678;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(ifa.in_ready), 0);
            tick();
            chk("bp_data", 32'(ifa.out_data), 32'h1234);
            chk("bp_valid", 32'(ifa.out_valid), 1);
            chk("bp_sel", 32'(ifa.out_sel), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ifa.in_ready), 32'h02);
        tick();
        chk("bp_next_data", 32'(ifa.out_data), 32'h5678);
        chk("bp_next_valid", 32'(ifa.out_valid), 1);
        in_valid = 8'h00;
        tick();
        chk("bp_drain", 32'(ifa.out_valid), 0);

        // burst lock on channel 3 with a bubble, channel 4 always asking
        in_data[4*W +: W] = 16'h4000;
        in_last[4]        = 1'b1;
        in_valid          = 8'h18;
        in_data[3*W +: W] = 16'h3000;
        in_last[3]        = 1'b0;
        tick();
        chk("lk_sel0", 32'(ifa.out_sel), 3);
        chk("lk_data0", 32'(ifa.out_data), 32'h3000);
        chk("lk_last0", 32'(ifa.out_last), 0);
        in_data[3*W +: W] = 16'h3001;
        tick();
        chk("lk_sel1", 32'(ifa.out_sel), 3);
        chk("lk_data1", 32'(ifa.out_data), 32'h3001);
        in_valid = 8'h10;
        #1;
        chk("lk_bubble_ready", 32'(ifa.in_ready), 0);
        tick();
        chk("lk_bubble_valid", 32'(ifa.out_valid), 0);
        in_valid          = 8'h18;
        in_data[3*W +: W] = 16'h3002;
        tick();
        chk("lk_sel2", 32'(ifa.out_sel), 3);
        chk("lk_data2", 32'(ifa.out_data), 32'h3002);
        in_data[3*W +: W] = 16'h3003;
        in_last[3]        = 1'b1;
        tick();
        chk("lk_sel3", 32'(ifa.out_sel), 3);
        chk("lk_data3", 32'(ifa.out_data), 32'h3003);
        chk("lk_last3", 32'(ifa.out_last), 1);
        in_valid = 8'h10;
        tick();
        chk("lk_after_sel", 32'(ifa.out_sel), 4);
        chk("lk_after_data", 32'(ifa.out_data), 32'h4000);
        in_valid = 8'h00;
        tick();
        reset_pulse();

        // no locking: channel 3 never ends its burst yet still interleaves with 4
        in_data[3*W +: W] = 16'h3000;
        in_last           = 8'h10;
        in_valid          = 8'h18;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("free_sel", 32'(ifb.out_sel), (k % 2 == 0) ? 3 : 4);
        end
        in_valid = 8'h00;
        tick();
        reset_pulse();

        // reset while locked on channel 5 with a stalled word
        out_ready = 1'b0;
        in_last   = 8'h00;
        in_valid  = 8'h20;
        tick();
        chk("r5_sel", 32'(ifa.out_sel), 5);
        chk("r5_valid", 32'(ifa.out_valid), 1);
        in_valid = 8'h21;
        #1;
        chk("r5_stall_ready", 32'(ifa.in_ready), 0);
        reset_n = 1'b0;
        #1;
        chk("r5_rst_valid", 32'(ifa.out_valid), 0);
        chk("r5_rst_data", 32'(ifa.out_data), 0);
        chk("r5_rst_sel", 32'(ifa.out_sel), 0);
        chk("r5_rst_last", 32'(ifa.out_last), 0);
        chk("r5_rst_ready", 32'(ifa.in_ready), 0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        in_last   = 8'h21;
        #1;
        chk("r5_post_ready", 32'(ifa.in_ready), 32'h01);
        tick();
        chk("r5_post_sel", 32'(ifa.out_sel), 0);
        chk("r5_post_data", 32'(ifa.out_data), 32'h0A00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
